// File: rtl/flip_bundle_driver.sv
// flip_bundle_driver
//   Stimulus/check end of the nested flipped-bundle pass-through interface.
//   Issues io_count beats (x=k, y=~k, z=3k), then checks each response beat
//   LATENCY cycles later against the pass-through mapping a=b=x, c=y, d=z.
//
// Ports
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   io_start, io_count  : run request and beat count (accepted in IDLE/DONE)
//   io_bio_aio_x, io_bio_y, io_z          : stimulus fields
//   io_bio_aio_a, io_bio_aio_b, io_bio_c, io_d : response fields
//   io_busy, io_done    : status (RUN/DRAIN, DONE)
//   io_errors           : saturating count of mismatching beats
//   io_err_mask         : sticky per-field mismatch {a,b,c,d}
//   io_first_err        : beat index of the first mismatch in the run
module flip_bundle_driver #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 0,
   parameter int CNT_W   = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_start,
   input  logic [CNT_W-1:0] io_count,
   output logic [WIDTH-1:0] io_bio_aio_x,
   output logic [WIDTH-1:0] io_bio_y,
   output logic [WIDTH-1:0] io_z,
   input  logic [WIDTH-1:0] io_bio_aio_a,
   input  logic [WIDTH-1:0] io_bio_aio_b,
   input  logic [WIDTH-1:0] io_bio_c,
   input  logic [WIDTH-1:0] io_d,
   output logic             io_busy,
   output logic             io_done,
   output logic [CNT_W-1:0] io_errors,
   output logic [3:0]       io_err_mask,
   output logic [CNT_W-1:0] io_first_err
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam int PD = (LATENCY > 0) ? LATENCY : 1;
   localparam logic [2:0] DRAIN_LAST = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;
   localparam logic [CNT_W-1:0] ERR_MAX = '1;

   state_t           state;
   logic [CNT_W-1:0] k;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       drain_cnt;
   logic [CNT_W-1:0] errors;
   logic [CNT_W-1:0] first_err;
   logic [3:0]       err_mask;

   logic             start_acc;
   logic             ck_vld;
   logic [CNT_W-1:0] ck_k;
   logic [WIDTH-1:0] ex_x, ex_y, ex_z;
   logic [3:0]       mm;

   function automatic logic [WIDTH-1:0] stim_x(input logic [CNT_W-1:0] kk);
      return WIDTH'(kk);
   endfunction

   function automatic logic [WIDTH-1:0] stim_y(input logic [CNT_W-1:0] kk);
      return ~stim_x(kk);
   endfunction

   function automatic logic [WIDTH-1:0] stim_z(input logic [CNT_W-1:0] kk);
      logic [WIDTH-1:0] v;
      v = stim_x(kk);
      return v + (v << 1);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == ERR_MAX) ? v : v + CNT_W'(1);
   endfunction

   assign start_acc = io_start && ((state == IDLE) || (state == DONE));

   // Stimulus: combinational decode of registered state/k, zero outside RUN
   assign io_bio_aio_x = (state == RUN) ? stim_x(k) : '0;
   assign io_bio_y     = (state == RUN) ? stim_y(k) : '0;
   assign io_z         = (state == RUN) ? stim_z(k) : '0;
   assign io_busy      = (state == RUN) || (state == DRAIN);
   assign io_done      = (state == DONE);
   assign io_errors    = errors;
   assign io_err_mask  = err_mask;
   assign io_first_err = first_err;

   // Check pipeline: {valid, k} delayed by LATENCY cycles
   generate
      if (LATENCY == 0) begin : g_comb
         assign ck_vld = (state == RUN);
         assign ck_k   = k;
      end else begin : g_pipe
         logic [PD-1:0]            vld_p;
         logic [PD-1:0][CNT_W-1:0] k_p;

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               vld_p <= '0;
               k_p   <= '0;
            end else begin
               vld_p[0] <= (state == RUN);
               k_p[0]   <= k;
               for (int i = 1; i < PD; i++) begin
                  vld_p[i] <= vld_p[i-1];
                  k_p[i]   <= k_p[i-1];
               end
            end
         end

         assign ck_vld = vld_p[PD-1];
         assign ck_k   = k_p[PD-1];
      end
   endgenerate

   // Check stage: expected values recomputed from the delayed beat index
   assign ex_x = stim_x(ck_k);
   assign ex_y = stim_y(ck_k);
   assign ex_z = stim_z(ck_k);
   assign mm   = {io_bio_aio_a != ex_x, io_bio_aio_b != ex_x,
                  io_bio_c != ex_y, io_d != ex_z};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         k         <= '0;
         cnt       <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (io_start) begin
                  k         <= '0;
                  drain_cnt <= '0;
                  if (io_count != '0) begin
                     cnt   <= io_count;
                     state <= RUN;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            RUN: begin
               // Last beat leaves k at 0 so a full-range count never wraps early
               if (k == cnt - CNT_W'(1)) begin
                  k         <= '0;
                  drain_cnt <= '0;
                  state     <= (LATENCY > 0) ? DRAIN : DONE;
               end else begin
                  k <= k + CNT_W'(1);
               end
            end
            DRAIN: begin
               if (drain_cnt == DRAIN_LAST) state <= DONE;
               else drain_cnt <= drain_cnt + 3'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Results: cleared on accepted start, updated at the end of each check cycle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         errors    <= '0;
         first_err <= '0;
         err_mask  <= '0;
      end else if (start_acc) begin
         errors    <= '0;
         first_err <= '0;
         err_mask  <= '0;
      end else if (ck_vld && (mm != 4'b0000)) begin
         err_mask <= err_mask | mm;
         errors   <= sat_inc(errors);
         if (errors == '0) first_err <= ck_k;
      end
   end

endmodule

// File: tb/tb_flip_bundle_driver.sv
module tb_flip_bundle_driver;

   localparam int W = 32;
   localparam int C = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int passed = 0;

   // Instance 0: LATENCY=0, combinational responder with optional d fault
   logic         st0 = 1'b0;
   logic [C-1:0] cn0 = '0;
   logic [W-1:0] x0, y0, z0, a0, b0, c0, d0;
   logic         busy0, done0;
   logic [C-1:0] err0, fe0;
   logic [3:0]   mask0;
   logic         stuck = 1'b0;

   assign a0 = x0;
   assign b0 = x0;
   assign c0 = y0;
   assign d0 = stuck ? '0 : z0;

   flip_bundle_driver #(.WIDTH(W), .LATENCY(0), .CNT_W(C)) u_l0 (
      .clock(clk), .reset(rst_n), .io_start(st0), .io_count(cn0),
      .io_bio_aio_x(x0), .io_bio_y(y0), .io_z(z0),
      .io_bio_aio_a(a0), .io_bio_aio_b(b0), .io_bio_c(c0), .io_d(d0),
      .io_busy(busy0), .io_done(done0), .io_errors(err0),
      .io_err_mask(mask0), .io_first_err(fe0));

   // Instances 1 and 2: each paired with a 2-cycle registered responder
   logic         st1 = 1'b0, st2 = 1'b0;
   logic [C-1:0] cn1 = '0, cn2 = '0;
   logic [W-1:0] x1, y1, z1, x2, y2, z2;
   logic [W-1:0] r1x_q, r1y_q, r1z_q, r1x, r1y, r1z;
   logic [W-1:0] r2x_q, r2y_q, r2z_q, r2x, r2y, r2z;
   logic         busy1, done1, busy2, done2;
   logic [C-1:0] err1, fe1, err2, fe2;
   logic [3:0]   mask1, mask2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1x_q <= '0; r1y_q <= '0; r1z_q <= '0; r1x <= '0; r1y <= '0; r1z <= '0;
         r2x_q <= '0; r2y_q <= '0; r2z_q <= '0; r2x <= '0; r2y <= '0; r2z <= '0;
      end else begin
         r1x_q <= x1; r1y_q <= y1; r1z_q <= z1; r1x <= r1x_q; r1y <= r1y_q; r1z <= r1z_q;
         r2x_q <= x2; r2y_q <= y2; r2z_q <= z2; r2x <= r2x_q; r2y <= r2y_q; r2z <= r2z_q;
      end
   end

   flip_bundle_driver #(.WIDTH(W), .LATENCY(1), .CNT_W(C)) u_l1 (
      .clock(clk), .reset(rst_n), .io_start(st1), .io_count(cn1),
      .io_bio_aio_x(x1), .io_bio_y(y1), .io_z(z1),
      .io_bio_aio_a(r1x), .io_bio_aio_b(r1x), .io_bio_c(r1y), .io_d(r1z),
      .io_busy(busy1), .io_done(done1), .io_errors(err1),
      .io_err_mask(mask1), .io_first_err(fe1));

   flip_bundle_driver #(.WIDTH(W), .LATENCY(2), .CNT_W(C)) u_l2 (
      .clock(clk), .reset(rst_n), .io_start(st2), .io_count(cn2),
      .io_bio_aio_x(x2), .io_bio_y(y2), .io_z(z2),
      .io_bio_aio_a(r2x), .io_bio_aio_b(r2x), .io_bio_c(r2y), .io_d(r2z),
      .io_busy(busy2), .io_done(done2), .io_errors(err2),
      .io_err_mask(mask2), .io_first_err(fe2));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      total++; if ({x0, y0, z0} !== '0) $display("FAIL reset_stim got=%h exp=0", {x0, y0, z0}); else passed++;
      total++; if ({busy0, done0} !== 2'b00) $display("FAIL reset_status got=%b exp=00", {busy0, done0}); else passed++;
      total++; if ({err0, fe0, mask0} !== '0) $display("FAIL reset_results got=%h exp=0", {err0, fe0, mask0}); else passed++;
      rst_n = 1'b1;
      step();
      step();
      total++; if ({busy0, done0} !== 2'b00) $display("FAIL idle_status got=%b exp=00", {busy0, done0}); else passed++;
   endtask

   task automatic test_pass_l0();
      logic [W-1:0] ek;
      st0 = 1'b1; cn0 = 16'd4;
      step();
      st0 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ek = W'(i);
         total++; if (x0 !== ek) $display("FAIL l0_x beat=%0d got=%h exp=%h", i, x0, ek); else passed++;
         total++; if (y0 !== ~ek) $display("FAIL l0_y beat=%0d got=%h exp=%h", i, y0, ~ek); else passed++;
         total++; if (z0 !== W'(3 * i)) $display("FAIL l0_z beat=%0d got=%h exp=%h", i, z0, W'(3 * i)); else passed++;
         total++; if (busy0 !== 1'b1) $display("FAIL l0_busy beat=%0d got=%b exp=1", i, busy0); else passed++;
         step();
      end
      total++; if ({busy0, done0} !== 2'b01) $display("FAIL l0_end_status got=%b exp=01", {busy0, done0}); else passed++;
      total++; if (err0 !== 16'd0) $display("FAIL l0_errors got=%0d exp=0", err0); else passed++;
      total++; if (mask0 !== 4'b0000) $display("FAIL l0_mask got=%b exp=0000", mask0); else passed++;
      total++; if (x0 !== '0) $display("FAIL l0_idle_x got=%h exp=0", x0); else passed++;
   endtask

   task automatic test_latency();
      int busy_cyc;
      busy_cyc = 0;
      st1 = 1'b1; cn1 = 16'd5; st2 = 1'b1; cn2 = 16'd5;
      step();
      st1 = 1'b0; st2 = 1'b0;
      for (int i = 0; i < 30 && !done2; i++) begin
         if (busy2) busy_cyc++;
         step();
      end
      total++; if (done2 !== 1'b1) $display("FAIL l2_done got=%b exp=1", done2); else passed++;
      total++; if (busy_cyc != 7) $display("FAIL l2_busy_cycles got=%0d exp=7", busy_cyc); else passed++;
      total++; if (err2 !== 16'd0) $display("FAIL l2_errors got=%0d exp=0", err2); else passed++;
      total++; if (done1 !== 1'b1) $display("FAIL l1_done got=%b exp=1", done1); else passed++;
      total++; if (err1 !== 16'd5) $display("FAIL l1_errors got=%0d exp=5", err1); else passed++;
      total++; if (fe1 !== 16'd0) $display("FAIL l1_first_err got=%0d exp=0", fe1); else passed++;
      total++; if (mask1 !== 4'b1111) $display("FAIL l1_mask got=%b exp=1111", mask1); else passed++;
   endtask

   task automatic test_stuck_d();
      stuck = 1'b1;
      st0 = 1'b1; cn0 = 16'd3;
      step();
      st0 = 1'b0;
      step();
      total++; if (err0 !== 16'd0) $display("FAIL stuck_beat0 got=%0d exp=0", err0); else passed++;
      step();
      step();
      total++; if (done0 !== 1'b1) $display("FAIL stuck_done got=%b exp=1", done0); else passed++;
      total++; if (err0 !== 16'd2) $display("FAIL stuck_errors got=%0d exp=2", err0); else passed++;
      total++; if (mask0 !== 4'b0001) $display("FAIL stuck_mask got=%b exp=0001", mask0); else passed++;
      total++; if (fe0 !== 16'd1) $display("FAIL stuck_first_err got=%0d exp=1", fe0); else passed++;
   endtask

   task automatic test_restart_clear();
      stuck = 1'b0;
      st0 = 1'b1; cn0 = 16'd2;
      step();
      st0 = 1'b0;
      total++; if (err0 !== 16'd0) $display("FAIL restart_errors got=%0d exp=0", err0); else passed++;
      total++; if (mask0 !== 4'b0000) $display("FAIL restart_mask got=%b exp=0000", mask0); else passed++;
      total++; if (fe0 !== 16'd0) $display("FAIL restart_first_err got=%0d exp=0", fe0); else passed++;
      step();
      step();
      total++; if (done0 !== 1'b1) $display("FAIL restart_done got=%b exp=1", done0); else passed++;
   endtask

   task automatic test_count_zero();
      stuck = 1'b1;
      st0 = 1'b1; cn0 = 16'd0;
      step();
      st0 = 1'b0;
      total++; if ({busy0, done0} !== 2'b01) $display("FAIL zero_status got=%b exp=01", {busy0, done0}); else passed++;
      total++; if ({x0, y0, z0} !== '0) $display("FAIL zero_stim got=%h exp=0", {x0, y0, z0}); else passed++;
      step();
      total++; if ({busy0, err0} !== '0) $display("FAIL zero_quiet got=%h exp=0", {busy0, err0}); else passed++;
      stuck = 1'b0;
   endtask

   task automatic test_start_ignored();
      st0 = 1'b1; cn0 = 16'd4;
      step();
      st0 = 1'b0;
      step();
      st0 = 1'b1; cn0 = 16'd1;
      step();
      st0 = 1'b0;
      total++; if (x0 !== 32'd2) $display("FAIL ign_x got=%h exp=2", x0); else passed++;
      step();
      total++; if ({busy0, x0} !== {1'b1, 32'd3}) $display("FAIL ign_beat3 got=%b/%h exp=1/3", busy0, x0); else passed++;
      step();
      total++; if ({busy0, done0} !== 2'b01) $display("FAIL ign_end got=%b exp=01", {busy0, done0}); else passed++;
   endtask

   task automatic test_reset_midrun();
      stuck = 1'b1;
      st0 = 1'b1; cn0 = 16'd6;
      step();
      st0 = 1'b0;
      step();
      step();
      total++; if ({x0, err0} !== {32'd2, 16'd1}) $display("FAIL pre_reset got=%h/%0d exp=2/1", x0, err0); else passed++;
      rst_n = 1'b0;
      #1;
      total++; if ({x0, y0, z0} !== '0) $display("FAIL async_stim got=%h exp=0", {x0, y0, z0}); else passed++;
      total++; if ({busy0, done0, err0, mask0, fe0} !== '0) $display("FAIL async_results got=%h exp=0", {busy0, done0, err0, mask0, fe0}); else passed++;
      #2;
      rst_n = 1'b1;
      stuck = 1'b0;
      step();
      total++; if ({busy0, done0, err0} !== '0) $display("FAIL post_reset got=%h exp=0", {busy0, done0, err0}); else passed++;
   endtask

   initial begin
      test_reset();
      test_pass_l0();
      test_latency();
      test_stuck_d();
      test_restart_clear();
      test_count_zero();
      test_start_ignored();
      test_reset_midrun();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
